// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the KGP-miniRISC fetch stage: produces next_addr for the PC
// register, with wait-state insertion, branch flush and halt. PC_SEQ_PERF_CNT_EN adds perf counters.
module pc_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              branch_rel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] next_addr,
    output logic              instr_valid,
    output logic              flush,
    output logic              halted
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       branch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              fetch_done;
    logic              advance;
    logic [ADDR_W-1:0] target;

    // wait_cnt never exceeds WAIT_LAST, so equality marks the end of the fetch
    assign fetch_done  = (state == RUN) && (wait_cnt == WAIT_LAST);
    assign instr_valid = rst && fetch_done;
    assign advance     = instr_valid && !stall;
    assign target      = branch_rel ? (instr_addr + branch_target) : branch_target;

    always_comb begin
        next_addr = instr_addr;
        if (!rst) begin
            next_addr = {ADDR_W{1'b1}};
        end else if (state == IDLE) begin
            if (start) next_addr = instr_addr + 1'b1;
        end else if (advance && !halt) begin
            next_addr = branch_taken ? target : instr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            flush    <= 1'b0;
            halted   <= 1'b0;
`ifdef PC_SEQ_PERF_CNT_EN
            retired_cnt <= '0;
            branch_cnt  <= '0;
`endif
        end else begin
            flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!fetch_done) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (advance) begin
                        wait_cnt <= '0;
`ifdef PC_SEQ_PERF_CNT_EN
                        retired_cnt <= retired_cnt + 32'd1;
`endif
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if (branch_taken) begin
                            flush <= 1'b1;
`ifdef PC_SEQ_PERF_CNT_EN
                            branch_cnt <= branch_cnt + 32'd1;
`endif
                        end
                    end
                end
                HALTED: halted <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (MEM_WAIT 0 and 2) each closing the loop through a PC
// register, checked every cycle against a behavioural model plus directed literal checks.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stall, branch_taken, branch_rel, halt;
    logic [31:0] branch_target;
    logic        force_en;
    logic [31:0] force_val;

    logic [31:0] pc [2];
    logic [31:0] na [2];
    logic        iv [2];
    logic        fl [2];
    logic        hl [2];
`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] rc [2];
    logic [31:0] bc [2];
`endif

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer #(.ADDR_W(32), .MEM_WAIT(0), .WAIT_W(4)) u_w0 (
        .clk(clk), .rst(rst), .instr_addr(pc[0]), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_rel(branch_rel), .branch_target(branch_target),
        .halt(halt), .next_addr(na[0]), .instr_valid(iv[0]), .flush(fl[0]), .halted(hl[0])
`ifdef PC_SEQ_PERF_CNT_EN
        , .retired_cnt(rc[0]), .branch_cnt(bc[0])
`endif
    );

    pc_sequencer #(.ADDR_W(32), .MEM_WAIT(2), .WAIT_W(4)) u_w2 (
        .clk(clk), .rst(rst), .instr_addr(pc[1]), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_rel(branch_rel), .branch_target(branch_target),
        .halt(halt), .next_addr(na[1]), .instr_valid(iv[1]), .flush(fl[1]), .halted(hl[1])
`ifdef PC_SEQ_PERF_CNT_EN
        , .retired_cnt(rc[1]), .branch_cnt(bc[1])
`endif
    );

    // PC register in the environment; force models an external PC load
    always @(posedge clk)
        for (int i = 0; i < 2; i++) pc[i] <= force_en ? force_val : na[i];

    // Behavioural model: mode 0 = waiting for start, 1 = executing, 2 = stopped
    int          m_mode [2];
    int          m_age  [2];   // cycles spent on the current fetch
    logic        m_flush[2];
    logic [31:0] m_ret  [2];
    logic [31:0] m_brc  [2];
    bit          armed = 0;

    function automatic int mem_wait(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit m_valid(input int i);
        return rst && m_mode[i] == 1 && m_age[i] >= mem_wait(i);
    endfunction

    function automatic logic [31:0] m_next(input int i);
        if (!rst) return 32'hFFFF_FFFF;
        if (m_mode[i] == 0) return start ? pc[i] + 32'd1 : pc[i];
        if (m_mode[i] == 2 || !m_valid(i) || stall || halt) return pc[i];
        if (branch_taken) return branch_rel ? pc[i] + branch_target : branch_target;
        return pc[i] + 32'd1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_mode[i] = 0; m_age[i] = 0; m_flush[i] = 1'b0;
                m_ret[i] = '0; m_brc[i] = '0;
            end else begin
                m_flush[i] = 1'b0;
                if (m_mode[i] == 0 && start) begin
                    m_mode[i] = 1; m_age[i] = 0;
                end else if (m_mode[i] == 1) begin
                    if (!m_valid(i)) m_age[i] = m_age[i] + 1;
                    else if (!stall) begin
                        m_age[i] = 0;
                        m_ret[i] = m_ret[i] + 32'd1;
                        if (halt) m_mode[i] = 2;
                        else if (branch_taken) begin
                            m_flush[i] = 1'b1;
                            m_brc[i] = m_brc[i] + 32'd1;
                        end
                    end
                end
            end
        end
        if (!rst) armed = 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model next_addr[%0d]", i), na[i], m_next(i));
                chk($sformatf("model instr_valid[%0d]", i), 32'(iv[i]), 32'(m_valid(i)));
                chk($sformatf("model flush[%0d]", i), 32'(fl[i]), 32'(m_flush[i]));
                chk($sformatf("model halted[%0d]", i), 32'(hl[i]), 32'(m_mode[i] == 2));
`ifdef PC_SEQ_PERF_CNT_EN
                chk($sformatf("model retired_cnt[%0d]", i), rc[i], m_ret[i]);
                chk($sformatf("model branch_cnt[%0d]", i), bc[i], m_brc[i]);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_rel = 1'b0;
        halt = 1'b0; branch_target = '0; force_en = 1'b0; force_val = '0;

        tick(); tick();
        #1;
        chk("reset next_addr", na[0], 32'hFFFF_FFFF);
        chk("reset halted", 32'(hl[0]), 0);
        chk("reset flush", 32'(fl[0]), 0);
        chk("reset instr_valid", 32'(iv[0]), 0);
        chk("reset pc", pc[0], 32'hFFFF_FFFF);

        tick(); rst = 1'b1; start = 1'b1;
        #1 chk("start next_addr", na[0], 32'd0);
        tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("seq pc w0 k=%0d", k), pc[0], 32'(k));
            chk($sformatf("seq valid w0 k=%0d", k), 32'(iv[0]), 1);
            chk($sformatf("seq pc w2 k=%0d", k), pc[1], 32'(k / 3));
            chk($sformatf("seq valid w2 k=%0d", k), 32'(iv[1]), 32'(k % 3 == 2));
            tick();
        end

        stall = 1'b1;
        repeat (3) begin
            #1 chk("stall hold pc", pc[0], 32'd5);
            chk("stall hold next", na[0], 32'd5);
            tick();
        end
        stall = 1'b0;
        #1 chk("unstall pc", pc[0], 32'd5);
        tick();
        #1 chk("after stall pc", pc[0], 32'd6);

        tick(); branch_taken = 1'b1; branch_rel = 1'b0; branch_target = 32'h40;
        #1 chk("abs branch next", na[0], 32'h40);
        chk("abs branch no early flush", 32'(fl[0]), 0);
        tick(); branch_taken = 1'b0;
        #1 chk("abs branch pc", pc[0], 32'h40);
        chk("abs branch flush", 32'(fl[0]), 1);
        tick();
        #1 chk("flush one cycle", 32'(fl[0]), 0);
        chk("post branch pc", pc[0], 32'h41);

        tick(); branch_taken = 1'b1; branch_rel = 1'b1; branch_target = 32'hFFFF_FFFE;
        #1 chk("rel branch next", na[0], 32'h40);
        tick(); branch_taken = 1'b0; branch_rel = 1'b0;
        #1 chk("rel branch pc", pc[0], 32'h40);
        chk("rel branch flush", 32'(fl[0]), 1);

        tick(); halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        #1 chk("halt next", na[0], 32'h41);
        tick(); halt = 1'b0; branch_taken = 1'b0;
        #1 chk("halt pc", pc[0], 32'h41);
        chk("halt halted", 32'(hl[0]), 1);
        chk("halt no flush", 32'(fl[0]), 0);
        chk("halt no valid", 32'(iv[0]), 0);
        tick(); start = 1'b1;
        #1 chk("halted ignores start", na[0], 32'h41);
        tick(); start = 1'b0;
        #1 chk("still halted", 32'(hl[0]), 1);

        tick(); rst = 1'b0;
        #1 chk("reset from halted next", na[0], 32'hFFFF_FFFF);
        tick(); rst = 1'b1;
        #1 chk("reset cleared halted", 32'(hl[0]), 0);
        chk("idle hold", na[0], 32'hFFFF_FFFF);

        tick(); start = 1'b1;
        tick(); start = 1'b0; force_en = 1'b1; force_val = 32'hFFFF_FFFF;
        tick(); force_en = 1'b0;
        #1 chk("wrap pc", pc[0], 32'hFFFF_FFFF);
        chk("wrap next", na[0], 32'h0);

        tick(); rst = 1'b0;
        tick(); rst = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            branch_taken = (n == 3 || n == 6); branch_rel = 1'b1; branch_target = 32'd4;
            tick();
        end
        branch_taken = 1'b0; branch_rel = 1'b0;
        #1 chk("ten advances pc", pc[0], 32'd16);
`ifdef PC_SEQ_PERF_CNT_EN
        chk("retired_cnt", rc[0], 32'd10);
        chk("branch_cnt", bc[0], 32'd2);
`endif

        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        #1 chk("midwait halted w2", 32'(hl[1]), 0);
        chk("midwait valid w2", 32'(iv[1]), 0);
        chk("midwait flush w0", 32'(fl[0]), 0);
`ifdef PC_SEQ_PERF_CNT_EN
        chk("midwait retired", rc[0], 32'd0);
        chk("midwait branches", bc[0], 32'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst           = ($urandom_range(0, 99) >= 3);
            start         = ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 4) == 0);
            branch_rel    = $urandom_range(0, 1) == 1;
            halt          = ($urandom_range(0, 49) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 31))
                                                        : 32'($urandom());
            force_en      = ($urandom_range(0, 49) == 0);
            force_val     = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
        end
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the program counter register: produces its next_addr input every cycle from its current instr_addr and the control inputs.
- Decides whether the PC holds, increments, branches or halts.
- Inserts MEM_WAIT wait cycles per fetch for slow instruction memory.
- Pulses a pipeline flush on taken branches.
- Sits between the control unit/branch logic and the PC register in the KGP-miniRISC fetch stage.

Parameters:
- ADDR_W, 32: address width; PC and all address arithmetic.
- MEM_WAIT, 0: extra wait cycles per fetch. Legal range 0..15.
- WAIT_W, 4: width of the wait counter. Must satisfy 2^WAIT_W > MEM_WAIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising edge of clk).
- instr_addr  in  ADDR_W  current PC value (PC register output).
- start  in  1  begin execution; sampled only in IDLE.
- stall  in  1  hazard stall; blocks PC advance.
- branch_taken  in  1  taken branch/jump for the current instruction.
- branch_rel  in  1  1: target = instr_addr + branch_target; 0: target = branch_target.
- branch_target  in  ADDR_W  absolute address, or two's-complement offset.
- halt  in  1  current instruction is HALT.
- next_addr  out  ADDR_W  combinational; drives the PC register input.
- instr_valid  out  1  instruction word at instr_addr is valid this cycle.
- flush  out  1  registered; one-cycle pulse after a taken branch advance.
- halted  out  1  registered; high in HALTED state.

Behaviour:
- FSM states: IDLE, RUN, HALTED. Internal counter wait_cnt[WAIT_W-1:0].
- Reset (rst=0 at edge):
  - state=IDLE, wait_cnt=0, flush=0, halted=0.
  - While rst=0, next_addr = all-ones (-1), so the PC reloads -1 regardless of its own reset.
  - rst overrides everything, including mid-wait, mid-branch and HALTED.
- IDLE:
  - next_addr = instr_addr (hold); instr_valid=0.
  - start=1: next_addr = instr_addr+1 (-1 -> 0); next state RUN, wait_cnt=0.
- RUN:
  - instr_valid = (wait_cnt == MEM_WAIT).
  - advance = instr_valid & ~stall.
  - While wait_cnt < MEM_WAIT: wait_cnt increments; next_addr = instr_addr. stall does not freeze wait_cnt.
  - At wait_cnt == MEM_WAIT with stall=1: hold next_addr; wait_cnt stays at MEM_WAIT.
  - On advance, wait_cnt returns to 0 and priority is halt > branch_taken > sequential:
    - halt=1: next_addr = instr_addr; next state HALTED, halted=1 next cycle.
    - branch_taken=1: next_addr = target; flush=1 next cycle only.
    - otherwise: next_addr = instr_addr+1.
  - halt and branch inputs are ignored when advance=0.
  - start is ignored in RUN and HALTED.
- HALTED: next_addr = instr_addr; instr_valid=0; flush=0. Left only by reset.
- Arithmetic:
  - All sums are modulo 2^ADDR_W; 0xFFFFFFFF + 1 = 0x00000000.
  - Relative offsets are two's complement; wrap silently, no error flag.
- Throughput: MEM_WAIT=0 gives one instruction per cycle; otherwise one per MEM_WAIT+1 cycles, plus stall cycles.
- flush follows every taken branch, including back-to-back branches and a branch to the same address.

Optional Feature:
- Macro: PC_SEQ_PERF_CNT_EN.
- When defined, adds two outputs, each 32 bits and cleared by rst:
  - retired_cnt: increments on every advance, including the halting one.
  - branch_cnt: increments on every taken-branch advance.
  - Both wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then start, MEM_WAIT=0:
  - rst=0 for 2 cycles -> next_addr=0xFFFFFFFF, halted=0, flush=0.
  - Release rst, pulse start -> instr_addr sequence 0,1,2,3 on consecutive cycles; instr_valid=1 each cycle.
- MEM_WAIT=2, no stall -> each address is held 3 cycles: 0,0,0,1,1,1; instr_valid high only on the 3rd cycle of each.
- Stall: at instr_addr=5, hold stall=1 for 3 cycles -> PC stays 5 for those 3 cycles, then 6.
- Branches:
  - Absolute: branch_taken=1, branch_rel=0, target=0x40 at PC=3 -> PC=0x40 next, flush=1 for exactly 1 cycle.
  - Relative: branch_rel=1, offset=0xFFFFFFFE at PC=0x40 -> PC=0x3E.
- Halt priority: halt=1 with branch_taken=1 at PC=7 -> PC stays 7, halted=1, flush=0.
  - Then start=1 -> no change.
  - Then rst=0 -> IDLE, next_addr=0xFFFFFFFF.
- Wrap and mid-operation reset:
  - Force PC=0xFFFFFFFF in RUN -> next_addr=0.
  - With PC_SEQ_PERF_CNT_EN: 10 advances including 2 taken branches -> retired_cnt=10, branch_cnt=2.
  - rst=0 mid-wait -> counters 0, state IDLE.
